fpu_scheduler: RTL and testbench



---
 rtl/fpu_pkg.sv | 28 ++
 rtl/fpu_rr_arbiter.sv | 50 +++++
 rtl/fpu_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_fpu_scheduler.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types for the FPU request scheduler.
// Holds the opcode and FSM state enums plus the datapath word width.
package fpu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } sched_state_t;

    // Negate an IEEE-754 single by flipping its sign bit.
    function automatic logic [WORD_W-1:0] neg_sign(
        input logic [WORD_W-1:0] v
    );
        return {~v[WORD_W-1], v[WORD_W-2:0]};
    endfunction

endpackage

// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter: round-robin arbiter with a rotating priority pointer.
// Ports: req (N requests), en (gate), advance (commit grant) -> grant, grant_idx.
module fpu_rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 en,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] kk;
    logic             found;
    int               k;

    // Scan from the pointer upward, wrapping once; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = 0;
        kk        = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr_q) + i;
            if (k >= N) k = k - N;
            kk = IDX_W'(k);
            if (en && !found && req[kk]) begin
                found     = 1'b1;
                grant[kk] = 1'b1;
                grant_idx = kk;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            if (grant_idx == IDX_W'(N - 1)) ptr_q <= '0;
            else                            ptr_q <= grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fpu_scheduler.sv
// fpu_scheduler: shares one add/mul/div FPU datapath among NUM_REQ requesters,
// one operation in flight at a time, round-robin arbitration.
// Ports: req_valid/req_ready/req_op/req_a/req_b per requester; resp_valid
// (one-hot), resp_ready, shared resp_data/resp_err; fpu_a/fpu_b operands,
// add/mul/div_valid start strobes, *_res/*_err unit results.
// Build option FPU_SCHED_STATS_EN adds op_count and err_count outputs.
module fpu_scheduler
    import fpu_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int FPU_LATENCY = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [WORD_W*NUM_REQ-1:0] req_a,
    input  logic [WORD_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [WORD_W-1:0]         resp_data,
    output logic                      resp_err,
    output logic [WORD_W-1:0]         fpu_a,
    output logic [WORD_W-1:0]         fpu_b,
    output logic                      add_valid,
    output logic                      mul_valid,
    output logic                      div_valid,
    input  logic [WORD_W-1:0]         add_res,
    input  logic [WORD_W-1:0]         mul_res,
    input  logic [WORD_W-1:0]         div_res,
    input  logic                      add_err,
    input  logic                      mul_err,
    input  logic                      div_err
`ifdef FPU_SCHED_STATS_EN
    ,
    output logic [31:0]               op_count,
    output logic [15:0]               err_count
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;

    sched_state_t state_q, state_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               arb_en;
    logic               accept;
    logic               resp_hs;
    logic               wait_done;

    logic [IDX_W-1:0]  g_q;
    op_t               op_q;
    logic [WORD_W-1:0] a_q;
    logic [WORD_W-1:0] b_q;
    logic [WORD_W-1:0] data_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    op_t               sel_op;
    logic [WORD_W-1:0] sel_a;
    logic [WORD_W-1:0] sel_b;
    logic [WORD_W-1:0] unit_res;
    logic              unit_err;

    // Gating with rst_n keeps req_ready low while reset is held.
    assign arb_en = (state_q == IDLE) && rst_n;

    fpu_rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .en        (arb_en),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign resp_hs   = (state_q == RESP) && resp_ready[g_q];
    assign wait_done = (state_q == WAIT) && (cnt_q == '0);

    assign sel_op = op_t'(req_op[{grant_idx, 1'b0} +: 2]);
    assign sel_a  = req_a[{grant_idx, 5'b0} +: WORD_W];
    assign sel_b  = req_b[{grant_idx, 5'b0} +: WORD_W];

    assign fpu_a     = a_q;
    assign fpu_b     = b_q;
    assign resp_data = data_q;
    assign resp_err  = err_q;

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = (state_q == RESP) && (g_q == IDX_W'(i));
        end
    end

    // Sub shares the adder: the sign flip happens on the operand.
    always_comb begin
        unit_res = add_res;
        unit_err = add_err;
        unique case (op_q)
            OP_ADD, OP_SUB: begin
                unit_res = add_res;
                unit_err = add_err;
            end
            OP_MUL: begin
                unit_res = mul_res;
                unit_err = mul_err;
            end
            OP_DIV: begin
                unit_res = div_res;
                unit_err = div_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        add_valid = 1'b0;
        mul_valid = 1'b0;
        div_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT;
                unique case (op_q)
                    OP_ADD, OP_SUB: add_valid = 1'b1;
                    OP_MUL:         mul_valid = 1'b1;
                    OP_DIV:         div_valid = 1'b1;
                    default: ;
                endcase
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
            end
            RESP: begin
                if (resp_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q    <= '0;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                g_q  <= grant_idx;
                op_q <= sel_op;
                a_q  <= sel_a;
                b_q  <= (sel_op == OP_SUB) ? neg_sign(sel_b) : sel_b;
            end
            // FPU_LATENCY-1 down to 0 gives FPU_LATENCY WAIT cycles.
            if (state_q == ISSUE) begin
                cnt_q <= CNT_W'(FPU_LATENCY - 1);
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (wait_done) begin
                data_q <= unit_res;
                err_q  <= unit_err;
            end
        end
    end

`ifdef FPU_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count  <= '0;
            err_count <= '0;
        end else if (resp_hs) begin
            op_count <= op_count + 1'b1;
            if (err_q && err_count != 16'hFFFF) begin
                err_count <= err_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_scheduler.sv
// tb_fpu_scheduler: randomized + directed bench for fpu_scheduler with a
// transaction-level reference model and behavioural FPU units.
module tb_fpu_scheduler;

    localparam int N = 4;
    localparam int L = 12;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [2*N-1:0]  req_op = '0;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready = '1;
    logic [31:0]     resp_data;
    logic            resp_err;
    logic [31:0]     fpu_a, fpu_b;
    logic            add_valid, mul_valid, div_valid;
    logic [31:0]     add_res, mul_res, div_res;
    logic            add_err, mul_err, div_err;
`ifdef FPU_SCHED_STATS_EN
    logic [31:0]     op_count;
    logic [15:0]     err_count;
`endif

    fpu_scheduler #(.NUM_REQ(N), .FPU_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .fpu_a(fpu_a), .fpu_b(fpu_b),
        .add_valid(add_valid), .mul_valid(mul_valid), .div_valid(div_valid),
        .add_res(add_res), .mul_res(mul_res), .div_res(div_res),
        .add_err(add_err), .mul_err(mul_err), .div_err(div_err)
`ifdef FPU_SCHED_STATS_EN
        , .op_count(op_count), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural FPU units ----------------
    function automatic real s2r(input logic [31:0] v);
        logic [10:0] e;
        if (v[30:23] == 8'd0) return 0.0;
        e = {3'b000, v[30:23]} + 11'd896;
        return $bitstoreal({v[31], e, v[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e <= 11'd896) return 32'h0;
        if (e >= 11'd1151) return {d[63], 8'hFF, 23'd0};
        e = e - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // op: 00/01 add (b already sign-adjusted), 10 mul, 11 div -> {err,res}
    function automatic logic [32:0] f_unit(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            2'b10: return {b[1:0] == 2'b11, r2s(s2r(a) * s2r(b))};
            2'b11: begin
                if (b[30:23] == 8'd0) return {1'b1, 32'h7F800000};
                return {1'b0, r2s(s2r(a) / s2r(b))};
            end
            default: return {a[1:0] == 2'b11, r2s(s2r(a) + s2r(b))};
        endcase
    endfunction

    assign {add_err, add_res} = f_unit(2'b00, fpu_a, fpu_b);
    assign {mul_err, mul_res} = f_unit(2'b10, fpu_a, fpu_b);
    assign {div_err, div_res} = f_unit(2'b11, fpu_a, fpu_b);

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: one transaction timeline measured from acceptance.
    bit          m_busy = 0;
    int          m_t = 0;
    int          m_ptr = 0;
    int          m_g = 0;
    logic [1:0]  m_op = '0;
    logic [31:0] m_fa = '0, m_fb = '0, m_data = '0;
    logic        m_err = 1'b0;
    int          m_ops = 0;
    int          m_errs = 0;

    // Observations of the DUT used by directed literal checks.
    int          acc_cyc = 0, strobe_cyc = 0, rise_cyc = 0;
    int          n_strobe = 0, n_rise = 0;
    logic [2:0]  strobe_kind = '0;
    logic [31:0] strobe_fb = '0, rise_data = '0;
    logic        rise_err = 1'b0;
    logic [N-1:0] prev_rv = '0;
    int          glog[$];
    int          acc_log[$];

    always @(negedge clk) begin
        logic [N-1:0] e_ready, e_rv;
        logic [2:0]   e_strb;
        logic [31:0]  b;
        logic [32:0]  u;
        int           pick, k;

        if (!rst_n) begin
            m_busy = 0; m_t = 0; m_ptr = 0;
            m_fa = '0; m_fb = '0; m_data = '0; m_err = 1'b0;
            m_ops = 0; m_errs = 0;
        end

        e_ready = '0; e_rv = '0; e_strb = '0; pick = -1;
        if (rst_n && !m_busy) begin
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (pick < 0 && req_valid[k]) pick = k;
            end
            if (pick >= 0) e_ready[pick] = 1'b1;
        end
        if (m_busy && m_t == 1) begin
            case (m_op)
                2'b10:   e_strb = 3'b010;
                2'b11:   e_strb = 3'b001;
                default: e_strb = 3'b100;
            endcase
        end
        if (m_busy && m_t >= L + 2) e_rv[m_g] = 1'b1;

        chk("req_ready", req_ready, e_ready);
        chk("resp_valid", resp_valid, e_rv);
        chk("strobes", {add_valid, mul_valid, div_valid}, e_strb);
        chk("fpu_a", fpu_a, m_fa);
        chk("fpu_b", fpu_b, m_fb);
        if (!rst_n || e_rv != '0) begin
            chk("resp_data", resp_data, m_data);
            chk("resp_err", resp_err, m_err);
        end
`ifdef FPU_SCHED_STATS_EN
        chk("op_count", op_count, m_ops);
        chk("err_count", err_count, m_errs);
`endif

        if (rst_n && |(req_valid & req_ready)) begin
            acc_cyc = cyc;
            n_strobe = 0;
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i]) begin
                    glog.push_back(i);
                    acc_log.push_back(cyc);
                end
        end
        if (add_valid | mul_valid | div_valid) begin
            strobe_cyc = cyc;
            strobe_kind = {add_valid, mul_valid, div_valid};
            strobe_fb = fpu_b;
            n_strobe++;
        end
        if (resp_valid != '0 && prev_rv == '0) begin
            rise_cyc = cyc;
            rise_data = resp_data;
            rise_err = resp_err;
            n_rise++;
        end
        prev_rv = resp_valid;

        if (rst_n) begin
            if (!m_busy) begin
                if (pick >= 0) begin
                    m_busy = 1; m_t = 1; m_g = pick;
                    m_op = req_op[pick*2 +: 2];
                    m_fa = req_a[pick*32 +: 32];
                    b = req_b[pick*32 +: 32];
                    m_fb = (m_op == 2'b01) ? {~b[31], b[30:0]} : b;
                    u = f_unit(m_op, m_fa, m_fb);
                    {m_err, m_data} = u;
                    m_ptr = (pick + 1) % N;
                end
            end else if (m_t >= L + 2 && resp_ready[m_g]) begin
                m_busy = 0;
                m_ops++;
                if (m_err && m_errs < 16'hFFFF) m_errs++;
            end else begin
                m_t++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int g, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_op[g*2 +: 2] = op;
        req_a[g*32 +: 32] = a;
        req_b[g*32 +: 32] = b;
    endtask

    task automatic do_req(input int g, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        bit ok;
        set_req(g, op, a, b);
        req_valid[g] = 1'b1;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[g]) ok = 1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 req_valid[g] = 1'b0;
    endtask

    task automatic wait_rise(input int n0);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (n_rise > n0) ok = 1;
        end
        if (!ok) chk("resp_timeout", 0, 1);
    endtask

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'(110 + $urandom_range(0, 30)),
                23'($urandom)};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int n0, s0;
        logic [31:0] d0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single add on requester 0.
        n0 = n_rise;
        do_req(0, 2'b00, 32'h3F800000, 32'h40000000);
        wait_rise(n0);
        chk("add_strobe_cycle", strobe_cyc - acc_cyc, 1);
        chk("add_strobe_kind", strobe_kind, 3'b100);
        chk("add_strobe_count", n_strobe, 1);
        chk("add_resp_cycle", rise_cyc - acc_cyc, 14);
        chk("add_data", rise_data, 32'h40400000);
        chk("add_err", rise_err, 0);
        repeat (2) @(posedge clk);
        #1;

        // Sub on requester 1: operand sign flip.
        n0 = n_rise;
        do_req(1, 2'b01, 32'h40400000, 32'h3F800000);
        wait_rise(n0);
        chk("sub_fpu_b", strobe_fb, 32'hBF800000);
        chk("sub_data", rise_data, 32'h40000000);
        repeat (2) @(posedge clk);
        #1;

        // Divide by zero on requester 3.
        n0 = n_rise;
        do_req(3, 2'b11, 32'h3F800000, 32'h00000000);
        wait_rise(n0);
        chk("div0_strobe_kind", strobe_kind, 3'b001);
        chk("div0_err", rise_err, 1);
        repeat (2) @(posedge clk);
        #1;

        // Round-robin with all requesters valid.
        glog.delete();
        acc_log.delete();
        for (int i = 0; i < N; i++) set_req(i, 2'b00, rnd_fp(), rnd_fp());
        resp_ready = '1;
        req_valid = '1;
        for (int i = 0; i < 6 * (L + 3) && glog.size() < 5; i++)
            @(negedge clk);
        @(posedge clk);
        #1 req_valid = '0;
        if (glog.size() < 5) begin
            chk("rr_grant_count", glog.size(), 5);
        end else begin
            chk("rr_g0", glog[0], 0);
            chk("rr_g1", glog[1], 1);
            chk("rr_g2", glog[2], 2);
            chk("rr_g3", glog[3], 3);
            chk("rr_g4", glog[4], 0);
            chk("rr_interval", acc_log[1] - acc_log[0], L + 3);
        end
        repeat (L + 6) @(posedge clk);
        #1;

        // Backpressure on requester 2 while others keep requesting.
        n0 = n_rise;
        resp_ready = 4'b1011;
        set_req(2, 2'b10, rnd_fp(), rnd_fp());
        req_valid = 4'b1101;
        wait_rise(n0);
        d0 = rise_data;
        s0 = n_strobe;
        repeat (20) @(negedge clk);
        chk("bp_resp_valid", resp_valid, 4'b0100);
        chk("bp_data_stable", resp_data, d0);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_no_strobe", n_strobe, s0);
        chk("bp_grant", glog[glog.size()-1], 2);
        @(posedge clk);
        #1 req_valid = '0;
        resp_ready = '1;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of WAIT.
        n0 = n_rise;
        do_req(0, 2'b10, 32'h40400000, 32'h40000000);
        repeat (5) @(posedge clk);
        req_valid = 4'b1001;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_strobes", {add_valid, mul_valid, div_valid}, 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_fpu_b", fpu_b, 0);
        chk("rst_resp", {resp_err, resp_data}, 0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (L + 5) @(posedge clk);
        chk("rst_no_resp", n_rise, n0);
        #1;
        n0 = n_rise;
        set_req(3, 2'b00, rnd_fp(), rnd_fp());
        req_valid[3] = 1'b1;
        do_req(0, 2'b00, 32'h3F800000, 32'h3F800000);
        req_valid[3] = 1'b0;
        chk("rst_ptr_grant", glog[glog.size()-1], 0);
        wait_rise(n0);
        chk("rst_after_data", rise_data, 32'h40000000);
        repeat (3) @(posedge clk);
        #1;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                logic [31:0] bb;
                bb = ($urandom_range(0, 7) == 0) ? 32'h0 : rnd_fp();
                set_req(i, 2'($urandom), rnd_fp(), bb);
                req_valid[i] = 1'($urandom);
                resp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        resp_ready = '1;
        repeat (L + 6) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
